speck_key_expander: RTL
=======================

// Module: speck_key_expander
// PURPOSE
// Runtime-configurable Speck key schedule covering every key size for one word width W.
// Accepts an m-word master key (m = 2..M_MAX) and a round count, then generates round keys rk[0..R-1].
// Round keys stream out one per handshake on a valid/ready port and are retained in an internal RAM.
// The encrypt/decrypt datapaths can read the stored keys back by index.
// PARAMETERS
// W          32  word width in bits (Speck n); must be >= IW
// M_MAX      4   max key words; legal range 2..4
// ROUNDS_MAX 27  max round count R; depth of the round-key RAM
// ALPHA      8   right-rotate amount (set 7 when W=16)
// BETA       3   left-rotate amount (set 2 when W=16)
// Derived: MW=$clog2(M_MAX+1), RW=$clog2(ROUNDS_MAX+1), IW=$clog2(ROUNDS_MAX)
// PORTS
// clk       in  1        clock
// rst       in  1        synchronous reset, active-high
// start     in  1        1-cycle request; sampled only in IDLE
// key_flat  in  W*M_MAX  key_flat[j*W+:W] = key word j; word 0 = k0, words 1..m-1 = l0..l(m-2)
// m_sel     in  MW       key words m for this run
// rounds    in  RW       round count R for this run
// abort     in  1        cancel the run in progress
// rk_data   out W        current round key rk[rk_idx]
// rk_idx    out IW       index of rk_data
// rk_valid  out 1        rk_data is valid
// rk_ready  in  1        consumer accepts rk_data
// busy      out 1        run in progress
// done      out 1        1-cycle pulse: last key accepted, RAM complete
// err       out 1        1-cycle pulse: start rejected due to illegal config
// rd_addr   in  IW       RAM read index
// rd_data   out W        RAM[rd_addr], registered, 1-cycle latency
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, i=0, L buffer=0. RAM contents are not cleared.
// States: IDLE, GEN. Inputs key_flat, m_sel and rounds are captured at start and held for the whole run.
// IDLE + start:
//   - Config is legal when 2<=m_sel<=M_MAX and 1<=rounds<=ROUNDS_MAX.
//   - Illegal: stay IDLE; err=1 next cycle.
//   - Legal: go to GEN. Next cycle: busy=1, rk_valid=1, rk_idx=0, rk_data=k0.
//     L buffer = l0..l(m-2) in order; unused slots = 0.
// GEN, on rk_valid&rk_ready with index i:
//   - RAM[i] <= rk_data.
//   - If i==R-1: next cycle IDLE, busy=0, rk_valid=0, done=1 for one cycle.
//   - Else, in one cycle:
//       lnew = (k + ROR(L[0],ALPHA)) mod 2^W, XOR zero-extended i
//       k' = ROL(k,BETA) XOR lnew
//     Then shift L left one slot and place lnew in slot m-2.
//     Next cycle: rk_data=k', rk_idx=i+1.
// Backpressure: while rk_valid&!rk_ready, rk_data and rk_idx hold and no state advances.
// Throughput: 1 key/cycle when rk_ready is held high. Latency start->rk[0] = 1 cycle.
// start while busy: ignored, no err. start and abort in the same IDLE cycle: start wins.
// abort in GEN:
//   - Next cycle IDLE, busy=0, rk_valid=0, no done.
//   - RAM keeps the keys already written.
//   - A handshake in the same cycle is still written to RAM.
// rst mid-run: back to IDLE, no done. RAM content is undefined for consumers until the next done.
// Read port: rd_data <= RAM[rd_addr] every cycle, independent of state.
//   - If the same index is written in the same cycle, rd_data returns the old word.
//   - rd_addr>=R returns stale data.
// Arithmetic: all addition is mod 2^W. Rotates are by constant amounts within W.
// TESTING
// T1 W=32, m=4, R=27, key 1b1a1918_13121110_0b0a0908_03020100, rk_ready=1
//    -> rk0=03020100, rk1=131d0309; 27 consecutive valid cycles; done one cycle after idx 26.
// T2 W=16, A=7, B=2, m=4, R=22, key 1918_1110_0908_0100
//    -> rk0=0100, rk1=1512; done after 22 handshakes.
// T3 T1 with rk_ready toggled pseudo-randomly -> identical key sequence; values stable while stalled.
// T4 m_sel=1, then rounds=0, then rounds=28
//    -> err pulse each time, busy stays 0, no rk_valid.
// T5 abort after idx 5 accepted -> busy=0 next cycle, no done.
//    Then restart T1 -> full correct run with done.
// T6 After T1 done, sweep rd_addr 0..26 -> rd_data matches streamed keys one cycle later.
//    Also: start while busy has no effect; rst mid-run leaves busy=0, rk_valid=0, done=0.

Source files
------------

// File: rtl/speck_key_expander.sv
// Speck key schedule: runtime m/R, streams round keys on valid/ready
// and keeps them in a RAM with a registered read port.
module speck_key_expander #(
  parameter int W          = 32,
  parameter int M_MAX      = 4,
  parameter int ROUNDS_MAX = 27,
  parameter int ALPHA      = 8,
  parameter int BETA       = 3,
  localparam int MW = $clog2(M_MAX + 1),
  localparam int RW = $clog2(ROUNDS_MAX + 1),
  localparam int IW = $clog2(ROUNDS_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W*M_MAX-1:0] key_flat,
  input  logic [MW-1:0]     m_sel,
  input  logic [RW-1:0]     rounds,
  input  logic              abort,
  output logic [W-1:0]      rk_data,
  output logic [IW-1:0]     rk_idx,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [IW-1:0]     rd_addr,
  output logic [W-1:0]      rd_data
);

  typedef enum logic {IDLE, GEN} state_t;

  state_t state, state_n;

  logic [W-1:0]  l_q [M_MAX];
  logic [MW-1:0] m_q;
  logic [RW-1:0] r_q;
  logic [W-1:0]  ram [ROUNDS_MAX];

  logic         hs, legal, last;
  logic         load, adv, fin, bad, quit;
  logic [W-1:0] lnew, k_next;

  function automatic logic [W-1:0] ror(input logic [W-1:0] x);
    return (x >> ALPHA) | (x << (W - ALPHA));
  endfunction

  function automatic logic [W-1:0] rol(input logic [W-1:0] x);
    return (x << BETA) | (x >> (W - BETA));
  endfunction

  assign hs    = rk_valid & rk_ready;
  assign legal = (m_sel >= MW'(2)) && (m_sel <= MW'(M_MAX)) &&
                 (rounds >= RW'(1)) && (rounds <= RW'(ROUNDS_MAX));
  assign last  = (RW'(rk_idx) == r_q - RW'(1));
  assign lnew  = (rk_data + ror(l_q[0])) ^ W'(rk_idx);
  assign k_next = rol(rk_data) ^ lnew;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    bad     = 1'b0;
    quit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            load    = 1'b1;
            state_n = GEN;
          end else begin
            bad = 1'b1;
          end
        end
      end
      GEN: begin
        if (abort) begin
          quit    = 1'b1;
          state_n = IDLE;
        end else if (hs) begin
          if (last) begin
            fin     = 1'b1;
            state_n = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
    endcase
  end

  // l_q[M_MAX-1] stays zero; it feeds the top slot when shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m_q      <= '0;
      r_q      <= '0;
      for (int j = 0; j < M_MAX; j++) l_q[j] <= '0;
    end else begin
      done <= fin;
      err  <= bad;
      if (load) begin
        rk_data  <= key_flat[W-1:0];
        rk_idx   <= '0;
        rk_valid <= 1'b1;
        busy     <= 1'b1;
        m_q      <= m_sel;
        r_q      <= rounds;
        for (int j = 0; j < M_MAX - 1; j++)
          l_q[j] <= (j < int'(m_sel) - 1) ?
                    key_flat[(j+1)*W +: W] : '0;
      end else if (adv) begin
        rk_data <= k_next;
        rk_idx  <= rk_idx + IW'(1);
        for (int s = 0; s < M_MAX - 1; s++)
          l_q[s] <= (s == int'(m_q) - 2) ? lnew : l_q[s+1];
      end else if (fin || quit) begin
        rk_valid <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == GEN && hs)
      ram[rk_idx] <= rk_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (int'(rd_addr) < ROUNDS_MAX)
      rd_data <= ram[rd_addr];
  end

endmodule
